// File: rtl/ram32x8_pkg.sv
// Shared constants, types and default-content helpers for the 32x8 RAM.
// The default image is an ascending table so a binary-search client works out of reset.
package ram32x8_pkg;

  localparam int DEPTH  = 32;
  localparam int WIDTH  = 8;
  localparam int ADDR_W = 5;

  typedef logic [WIDTH-1:0]      word_t;
  typedef logic [ADDR_W-1:0]     addr_t;
  typedef word_t [DEPTH-1:0]     image_t;

  // Default content of one word: 4*i, always fits in 8 bits for i < 32.
  function automatic word_t init_word(input int unsigned i);
    return word_t'(i << 32'd2);
  endfunction

  // Full default memory image, used for power-up and reset reload.
  function automatic image_t init_image();
    image_t img;
    for (int unsigned i = 32'd0; i < DEPTH; i++) begin
      img[i] = init_word(i);
    end
    return img;
  endfunction

endpackage

// File: rtl/ram32x8.sv
// 32-word x 8-bit single-port flop RAM with registered address and unregistered read port.
// Reset reloads the ascending default image; read-during-write returns the new data.
module ram32x8
  import ram32x8_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] address,
  input  logic [WIDTH-1:0]  data,
  input  logic              wren,
  output logic [WIDTH-1:0]  q
);

  // Power-up value matches the reset image so reads before the first reset are defined.
  image_t mem_r  = init_image();
  addr_t  addr_r = {ADDR_W{1'b0}};

  // Memory array and address register; reset wins over any write in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_r  <= init_image();
      addr_r <= {ADDR_W{1'b0}};
    end else begin
      addr_r <= address;
      // Per-word enable keeps an unknown wren confined to the addressed word.
      for (int unsigned i = 32'd0; i < DEPTH; i++) begin
        if (wren && (address == addr_t'(i))) begin
          mem_r[i] <= data;
        end
      end
    end
  end

  // Read port: word at the registered address, so a just-written word appears immediately.
  always_comb begin
    q = mem_r[addr_r];
  end

endmodule

// File: tb/tb_ram32x8.sv
// Directed self-checking bench for ram32x8: reset image, sequential reads, writes,
// reset priority/discard, alternating read/write and unknown write-enable containment.
module tb_ram32x8;

  logic       clk;
  logic       reset;
  logic [4:0] address;
  logic [7:0] data;
  logic       wren;
  logic [7:0] q;

  int vectors;
  int miscompares;
  logic [7:0] model [8];

  ram32x8 dut (
    .clk     (clk),
    .reset   (reset),
    .address (address),
    .data    (data),
    .wren    (wren),
    .q       (q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] expected);
    vectors++;
    assert (q === expected) else begin
      miscompares++;
      $error("FAIL %s: q=%h expected=%h", tag, q, expected);
    end
  endtask

  task automatic drive(input logic r, input logic [4:0] a, input logic [7:0] d, input logic w);
    reset   = r;
    address = a;
    data    = d;
    wren    = w;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    drive(1'b0, 5'd7, 8'h00, 1'b0);
    #1;
    check("powerup_q0", 8'd0);
    tick();
    check("powerup_read7", 8'd28);

    drive(1'b1, 5'd9, 8'h00, 1'b0);
    tick();
    check("reset_q", 8'd0);

    for (int a = 0; a < 32; a++) begin
      drive(1'b0, 5'(a), 8'h00, 1'b0);
      tick();
      check($sformatf("seq_read_%0d", a), 8'(4 * a));
    end

    drive(1'b0, 5'd25, 8'h00, 1'b0); tick(); check("read25", 8'd100);
    drive(1'b0, 5'd16, 8'h00, 1'b0); tick(); check("read16", 8'd64);

    drive(1'b0, 5'd5, 8'hA5, 1'b1); tick(); check("write5_rdw", 8'hA5);
    drive(1'b0, 5'd4, 8'h00, 1'b0); tick(); check("read4_after_w5", 8'd16);
    drive(1'b0, 5'd5, 8'h00, 1'b0); tick(); check("reread5", 8'hA5);

    drive(1'b0, 5'd31, 8'h00, 1'b1); tick(); check("write31_rdw", 8'h00);
    drive(1'b1, 5'd31, 8'h00, 1'b0); tick(); check("reset_clears_addr", 8'd0);
    drive(1'b0, 5'd31, 8'h00, 1'b0); tick(); check("read31_after_reset", 8'd124);
    drive(1'b0, 5'd5, 8'h00, 1'b0);  tick(); check("read5_after_reset", 8'd20);

    drive(1'b1, 5'd3, 8'hFF, 1'b1); tick(); check("reset_vs_write_q", 8'd0);
    drive(1'b0, 5'd3, 8'h00, 1'b0); tick(); check("read3_write_dropped", 8'd12);

    for (int i = 0; i < 8; i++) model[i] = 8'(4 * i);
    for (int c = 0; c < 16; c++) begin
      if ((c % 2) == 0) begin
        drive(1'b0, 5'((c * 3) % 8), 8'(8'h40 + c), 1'b1);
        model[(c * 3) % 8] = 8'(8'h40 + c);
        tick();
        check($sformatf("alt_write_%0d", c), 8'(8'h40 + c));
      end else begin
        drive(1'b0, 5'((c * 5) % 8), 8'h00, 1'b0);
        tick();
        check($sformatf("alt_read_%0d", c), model[(c * 5) % 8]);
      end
    end

    drive(1'b1, 5'd0, 8'h00, 1'b0); tick();
    drive(1'b0, 5'd6, 8'hEE, 1'bx); tick();
    drive(1'b0, 5'd7, 8'h00, 1'b0); tick(); check("xwren_read7", 8'd28);
    drive(1'b0, 5'd2, 8'h00, 1'b0); tick(); check("xwren_read2", 8'd8);
    drive(1'b0, 5'd1, 8'h00, 1'b0); tick(); check("xwren_read1", 8'd4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
